rr_arb_out_queue: RTL and testbench

- Output buffer directly downstream of the 4-input round-robin arbiter.
- Captures each granted beat as a {chosen, bits} pair in a small FIFO, so arbiter grant timing is decoupled from the consumer.
- Keeps a per-source occupancy count so upstream logic can see which sources still have beats in flight.
- The enqueue side connects one-to-one to the arbiter's io_out_* and io_chosen outputs.

---
 rtl/rr_arb_out_queue.sv | 121 ++++++++++++
 tb/tb_rr_arb_out_queue.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/rr_arb_out_queue.sv
// rr_arb_out_queue: FIFO buffer behind the 4-input round-robin arbiter.
// Holds granted beats as {tag, bits} pairs and tracks per-source occupancy
// so upstream logic can see which sources still have beats in flight.
// Optional macro RR_ARB_OUT_QUEUE_FLOW_EN: flow-through bypass when empty.
module rr_arb_out_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    parameter int TAG_W = 2,
    localparam int NSRC = 1 << TAG_W,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             io_enq_valid,
    output logic             io_enq_ready,
    input  logic [WIDTH-1:0] io_enq_bits,
    input  logic [TAG_W-1:0] io_enq_tag,
    output logic             io_deq_valid,
    input  logic             io_deq_ready,
    output logic [WIDTH-1:0] io_deq_bits,
    output logic [TAG_W-1:0] io_deq_tag,
    output logic [CW-1:0]    io_count,
    output logic [NSRC-1:0]  io_src_pending
);

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [WIDTH-1:0] bits;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [PW-1:0]   wp;
    logic [PW-1:0]   rp;
    logic [CW-1:0]   count;
    logic [CW-1:0]   srccnt [NSRC];

    entry_t          head;
    logic            stored_valid;
    logic            bypass;
    logic            enq_fire;
    logic            deq_fire;
    logic [NSRC-1:0] src_inc;
    logic [NSRC-1:0] src_dec;

    assign head         = mem[rp];
    assign stored_valid = (count != '0);
    // Ready depends only on occupancy, so there is no comb path from io_deq_ready.
    assign io_enq_ready = (count != CW'(DEPTH));
    assign io_count     = count;

`ifdef RR_ARB_OUT_QUEUE_FLOW_EN
    // An empty queue hands an offered beat straight to the consumer.
    assign bypass       = !stored_valid && io_enq_valid && io_deq_ready;
    assign io_deq_valid = stored_valid || io_enq_valid;
    assign io_deq_bits  = stored_valid ? head.bits : io_enq_bits;
    assign io_deq_tag   = stored_valid ? head.tag  : io_enq_tag;
`else
    assign bypass       = 1'b0;
    assign io_deq_valid = stored_valid;
    assign io_deq_bits  = head.bits;
    assign io_deq_tag   = head.tag;
`endif

    // A bypassed beat is neither written nor read from storage.
    assign enq_fire = io_enq_valid && io_enq_ready && !bypass;
    assign deq_fire = stored_valid && io_deq_ready;

    // Decode which source counters step up or down this cycle.
    always_comb begin
        // NOTE: every comb output gets a default first so no latch is inferred.
        src_inc        = '0;
        src_dec        = '0;
        io_src_pending = '0;
        for (int k = 0; k < NSRC; k++) begin
            src_inc[k]        = enq_fire && (io_enq_tag == TAG_W'(k));
            src_dec[k]        = deq_fire && (head.tag == TAG_W'(k));
            io_src_pending[k] = (srccnt[k] != '0);
        end
    end

    // Pointer and occupancy state; pointers wrap naturally at power-of-two DEPTH.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: sequential state uses non-blocking assignments only.
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (enq_fire) wp <= wp + PW'(1);
            if (deq_fire) rp <= rp + PW'(1);
            case ({enq_fire, deq_fire})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Per-source occupancy counters; same-tag enq and deq cancel out.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NSRC; k++) srccnt[k] <= '0;
        end else begin
            for (int k = 0; k < NSRC; k++) begin
                case ({src_inc[k], src_dec[k]})
                    2'b10:   srccnt[k] <= srccnt[k] + CW'(1);
                    2'b01:   srccnt[k] <= srccnt[k] - CW'(1);
                    default: srccnt[k] <= srccnt[k];
                endcase
            end
        end
    end

    // Entry storage written on enqueue fire.
    // NOTE: the data array is deliberately not reset; io_deq_valid qualifies it.
    always_ff @(posedge clk) begin
        if (enq_fire) mem[wp] <= '{tag: io_enq_tag, bits: io_enq_bits};
    end

endmodule

// File: tb/tb_rr_arb_out_queue.sv
// tb_rr_arb_out_queue: directed self-checking bench for rr_arb_out_queue.
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_rr_arb_out_queue;

    logic       clk = 1'b0;
    logic       reset;
    logic       io_enq_valid;
    logic       io_enq_ready;
    logic [7:0] io_enq_bits;
    logic [1:0] io_enq_tag;
    logic       io_deq_valid;
    logic       io_deq_ready;
    logic [7:0] io_deq_bits;
    logic [1:0] io_deq_tag;
    logic [2:0] io_count;
    logic [3:0] io_src_pending;

    int checks = 0;
    int errors = 0;

    rr_arb_out_queue #(.DEPTH(4), .WIDTH(8), .TAG_W(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .io_enq_valid  (io_enq_valid),
        .io_enq_ready  (io_enq_ready),
        .io_enq_bits   (io_enq_bits),
        .io_enq_tag    (io_enq_tag),
        .io_deq_valid  (io_deq_valid),
        .io_deq_ready  (io_deq_ready),
        .io_deq_bits   (io_deq_bits),
        .io_deq_tag    (io_deq_tag),
        .io_count      (io_count),
        .io_src_pending(io_src_pending)
    );

    always #5 clk = ~clk;

    // Advance one full cycle, landing 1ns after the next falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; io_enq_valid = 1'b0; io_deq_ready = 1'b0;
        io_enq_bits = '0; io_enq_tag = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if (io_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", io_count); end
        checks++; if (io_deq_valid !== 1'b0) begin errors++; $display("FAIL reset_deq_valid: got %b expected 0", io_deq_valid); end
        checks++; if (io_enq_ready !== 1'b1) begin errors++; $display("FAIL reset_enq_ready: got %b expected 1", io_enq_ready); end
        checks++; if (io_src_pending !== 4'b0000) begin errors++; $display("FAIL reset_pending: got %b expected 0000", io_src_pending); end
        step();
        checks++; if (io_count !== 3'd0) begin errors++; $display("FAIL idle_count: got %0d expected 0", io_count); end
    endtask

    task automatic test_fill();
        logic [7:0] b [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        logic [1:0] t [4] = '{2'd0, 2'd1, 2'd2, 2'd1};
        io_deq_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            io_enq_valid = 1'b1; io_enq_bits = b[i]; io_enq_tag = t[i];
            #1;
            checks++; if (io_enq_ready !== 1'b1) begin errors++; $display("FAIL fill_ready[%0d]: got %b expected 1", i, io_enq_ready); end
            checks++; if (io_count !== 3'(i)) begin errors++; $display("FAIL fill_count[%0d]: got %0d expected %0d", i, io_count, i); end
            step();
        end
        checks++; if (io_count !== 3'd4) begin errors++; $display("FAIL full_count: got %0d expected 4", io_count); end
        checks++; if (io_enq_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b expected 0", io_enq_ready); end
        checks++; if (io_src_pending !== 4'b0111) begin errors++; $display("FAIL full_pending: got %b expected 0111", io_src_pending); end
        io_enq_bits = 8'h55; io_enq_tag = 2'd3;
        step();
        io_enq_valid = 1'b0;
        #1;
        checks++; if (io_count !== 3'd4) begin errors++; $display("FAIL overfill_count: got %0d expected 4", io_count); end
        checks++; if (io_src_pending !== 4'b0111) begin errors++; $display("FAIL overfill_pending: got %b expected 0111", io_src_pending); end
        checks++; if (io_deq_bits !== 8'h11) begin errors++; $display("FAIL overfill_head: got %h expected 11", io_deq_bits); end
    endtask

    task automatic test_drain();
        logic [7:0] b [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        logic [1:0] t [4] = '{2'd0, 2'd1, 2'd2, 2'd1};
        logic [3:0] p [5] = '{4'b0111, 4'b0110, 4'b0110, 4'b0010, 4'b0000};
        io_deq_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (io_src_pending !== p[i]) begin errors++; $display("FAIL drain_pending[%0d]: got %b expected %b", i, io_src_pending, p[i]); end
            checks++; if (io_deq_valid !== 1'b1) begin errors++; $display("FAIL drain_valid[%0d]: got %b expected 1", i, io_deq_valid); end
            checks++; if (io_deq_bits !== b[i]) begin errors++; $display("FAIL drain_bits[%0d]: got %h expected %h", i, io_deq_bits, b[i]); end
            checks++; if (io_deq_tag !== t[i]) begin errors++; $display("FAIL drain_tag[%0d]: got %0d expected %0d", i, io_deq_tag, t[i]); end
            step();
        end
        checks++; if (io_src_pending !== p[4]) begin errors++; $display("FAIL drain_pending[4]: got %b expected %b", io_src_pending, p[4]); end
        checks++; if (io_deq_valid !== 1'b0) begin errors++; $display("FAIL drain_empty: got %b expected 0", io_deq_valid); end
        checks++; if (io_count !== 3'd0) begin errors++; $display("FAIL drain_count: got %0d expected 0", io_count); end
        io_deq_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_tag;
        // Preload beat 0 so the stream runs at count=1.
        io_deq_ready = 1'b0; io_enq_valid = 1'b1; io_enq_bits = 8'h00; io_enq_tag = 2'd3;
        step();
        io_deq_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp_tag = (i % 2 == 0) ? 2'd3 : 2'd0;
            if (i < 7) begin
                io_enq_valid = 1'b1; io_enq_bits = 8'(i + 1); io_enq_tag = ((i + 1) % 2 == 0) ? 2'd3 : 2'd0;
            end else begin
                io_enq_valid = 1'b0;
            end
            #1;
            checks++; if (io_count !== 3'd1) begin errors++; $display("FAIL stream_count[%0d]: got %0d expected 1", i, io_count); end
            checks++; if (io_deq_bits !== 8'(i)) begin errors++; $display("FAIL stream_bits[%0d]: got %h expected %h", i, io_deq_bits, 8'(i)); end
            checks++; if (io_deq_tag !== exp_tag) begin errors++; $display("FAIL stream_tag[%0d]: got %0d expected %0d", i, io_deq_tag, exp_tag); end
            step();
        end
        checks++; if (io_count !== 3'd0) begin errors++; $display("FAIL stream_end_count: got %0d expected 0", io_count); end
        checks++; if (io_src_pending !== 4'b0000) begin errors++; $display("FAIL stream_end_pending: got %b expected 0000", io_src_pending); end
        io_deq_ready = 1'b0;
    endtask

    task automatic test_full_simul();
        io_deq_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            io_enq_valid = 1'b1; io_enq_bits = 8'hA0 + 8'(i); io_enq_tag = 2'(i);
            step();
        end
        io_enq_bits = 8'hB0; io_enq_tag = 2'd3; io_deq_ready = 1'b1;
        #1;
        checks++; if (io_enq_ready !== 1'b0) begin errors++; $display("FAIL simul_c1_ready: got %b expected 0", io_enq_ready); end
        checks++; if (io_deq_bits !== 8'hA0) begin errors++; $display("FAIL simul_c1_head: got %h expected a0", io_deq_bits); end
        step();
        checks++; if (io_count !== 3'd3) begin errors++; $display("FAIL simul_c1_count: got %0d expected 3", io_count); end
        checks++; if (io_enq_ready !== 1'b1) begin errors++; $display("FAIL simul_c2_ready: got %b expected 1", io_enq_ready); end
        checks++; if (io_deq_bits !== 8'hA1) begin errors++; $display("FAIL simul_c2_head: got %h expected a1", io_deq_bits); end
        step();
        io_enq_valid = 1'b0; io_deq_ready = 1'b0;
        #1;
        checks++; if (io_count !== 3'd3) begin errors++; $display("FAIL simul_c2_count: got %0d expected 3", io_count); end
        checks++; if (io_deq_bits !== 8'hA2) begin errors++; $display("FAIL simul_c2_next: got %h expected a2", io_deq_bits); end
        checks++; if (io_src_pending !== 4'b1100) begin errors++; $display("FAIL simul_pending: got %b expected 1100", io_src_pending); end
    endtask

    task automatic test_reset_mid();
        // Entered 2ns after a falling edge with count=3; reset lands mid-cycle.
        #1;
        reset = 1'b0;
        #1;
        checks++; if (io_count !== 3'd0) begin errors++; $display("FAIL async_count: got %0d expected 0", io_count); end
        checks++; if (io_deq_valid !== 1'b0) begin errors++; $display("FAIL async_deq_valid: got %b expected 0", io_deq_valid); end
        checks++; if (io_src_pending !== 4'b0000) begin errors++; $display("FAIL async_pending: got %b expected 0000", io_src_pending); end
        checks++; if (io_enq_ready !== 1'b1) begin errors++; $display("FAIL async_enq_ready: got %b expected 1", io_enq_ready); end
        @(negedge clk);
        reset = 1'b1;
        #1;
    endtask

    task automatic test_empty_enq();
        io_enq_valid = 1'b1; io_enq_bits = 8'hA5; io_enq_tag = 2'd2; io_deq_ready = 1'b1;
        #1;
`ifdef RR_ARB_OUT_QUEUE_FLOW_EN
        checks++; if (io_deq_valid !== 1'b1) begin errors++; $display("FAIL flow_valid: got %b expected 1", io_deq_valid); end
        checks++; if (io_deq_bits !== 8'hA5) begin errors++; $display("FAIL flow_bits: got %h expected a5", io_deq_bits); end
        checks++; if (io_deq_tag !== 2'd2) begin errors++; $display("FAIL flow_tag: got %0d expected 2", io_deq_tag); end
        step();
        io_enq_valid = 1'b0;
        #1;
        checks++; if (io_count !== 3'd0) begin errors++; $display("FAIL flow_count: got %0d expected 0", io_count); end
        checks++; if (io_src_pending !== 4'b0000) begin errors++; $display("FAIL flow_pending: got %b expected 0000", io_src_pending); end
`else
        checks++; if (io_deq_valid !== 1'b0) begin errors++; $display("FAIL latency_same_cycle: got %b expected 0", io_deq_valid); end
        step();
        io_enq_valid = 1'b0;
        #1;
        checks++; if (io_deq_valid !== 1'b1) begin errors++; $display("FAIL latency_next_valid: got %b expected 1", io_deq_valid); end
        checks++; if (io_deq_bits !== 8'hA5) begin errors++; $display("FAIL latency_next_bits: got %h expected a5", io_deq_bits); end
        checks++; if (io_src_pending !== 4'b0100) begin errors++; $display("FAIL latency_pending: got %b expected 0100", io_src_pending); end
        step();
        checks++; if (io_count !== 3'd0) begin errors++; $display("FAIL latency_drained: got %0d expected 0", io_count); end
`endif
        io_deq_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_back_to_back();
        test_full_simul();
        test_reset_mid();
        test_empty_enq();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
